valu_addminmax_pipe: RTL and testbench
======================================

// Module: valu_addminmax_pipe
// PURPOSE
//  Parametrised SIMD integer add/sub/min/max/compare unit for the vector ALU; the
//  successor to the fixed 64-bit add/min-max block. Adds configurable datapath width,
//  valid/ready backpressure with bubble collapsing, packed compare masks, and optional
//  saturating add/sub. Sits between the vALU operand dispatch and the result writeback.
// PARAMETERS
//  DATA_WIDTH  64  operand/result width in bits; a multiple of 64 (64..512)
//  ADDR_WIDTH  32  width of the destination tag carried alongside each operation
//  SEW_WIDTH   2   element-width select: 0=8b, 1=16b, 2=32b, 3=64b
//  OP_WIDTH    4   opcode width
// PORTS
//  clk        in   1           clock
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           operation offered
//  in_ready   out  1           unit accepts the operation this cycle
//  in_vec0    in   DATA_WIDTH  operand A (vs2)
//  in_vec1    in   DATA_WIDTH  operand B (vs1/scalar-splat)
//  in_sew     in   SEW_WIDTH   element width
//  in_op      in   OP_WIDTH    opcode (see BEHAVIOUR)
//  in_sat     in   2           00 wrap, 10 unsigned sat, 11 signed sat (ADD/SUB only)
//  in_addr    in   ADDR_WIDTH  destination tag
//  out_valid  out  1           result available
//  out_ready  in   1           consumer accepts result
//  out_vec    out  DATA_WIDTH  result vector or packed mask
//  out_addr   out  ADDR_WIDTH  tag of the result
//  out_sat    out  1           any element saturated (vxsat contribution)
// BEHAVIOUR
//  - Reset: out_valid=0, out_vec=0, out_addr=0, out_sat=0, all stage valids 0; in_ready=0 while rst.
//  - Ops: 0 ADD, 1 SUB(A-B), 2 MINU, 3 MIN, 4 MAXU, 5 MAX, 8 SEQ, 9 SNE, A SLTU, B SLT,
//    C SLEU, D SLE, E SGTU, F SGT. Codes 6,7: reserved -> result all-zero, out_sat=0.
//  - Elements per vector N = DATA_WIDTH/(8<<sew); arithmetic wraps modulo element width.
//  - Compares: bit i of out_vec = result of element i (A op B); bits N..DATA_WIDTH-1 = 0.
//  - Pipeline: 3 registered stages (S1 operand capture, S2 add/sub + flags, S3 select/mask
//    pack = output register). Accepted in cycle T -> out_valid in T+3 with no stall.
//  - Handshake: transfer on valid&&ready both sides. Each stage advances when the next stage
//    is empty or advancing; bubbles collapse. in_ready = !S1.valid || S1 advances.
//  - out_valid held, out_vec/out_addr/out_sat stable while out_valid && !out_ready.
//  - Full pipe + out_ready=0: in_ready=0. Simultaneous output pop and input push on a full pipe
//    is legal and sustains 1 op/cycle.
//  - Ordering strictly in-order; out_addr always matches its own result.
//  - Reset mid-operation drops all in-flight ops; no output is produced for them.
//  - in_sat ignored for non-ADD/SUB ops and when the optional feature is absent.
// CONFIGURATION
//  VALU_SAT_EN defined: ADD/SUB with in_sat=10 clamp to [0, 2^w-1], in_sat=11 clamp to
//   [-2^(w-1), 2^(w-1)-1]; out_sat=1 if any active element clamped.
//  VALU_SAT_EN undefined: no saturation logic; ADD/SUB always wrap; out_sat tied 0.
// TESTING
//  1. sew=0, ADD 0x...FF01 + 0x...0101 -> low bytes 0x02,0x00 (wrap), out_valid at T+3, out_sat=0.
//  2. sew=2, SLT A={-1,5}, B={0,5} (32b elems) -> out_vec=0b01, upper bits 0; MAXU same -> {0xFFFFFFFF,5}.
//  3. 8 back-to-back ops, out_ready low 5 cycles mid-stream -> in_ready drops when 3 held,
//     no loss/duplication, tags in order, throughput 1/cycle after release.
//  4. Single op then out_ready=0 with bubbles -> in_ready stays 1 until stages fill.
//  5. VALU_SAT_EN: sew=0 signed ADD 0x7F+0x01 -> 0x7F, out_sat=1; unsigned SUB 0x00-0x01 -> 0x00;
//     without macro same stimulus -> 0x80 / 0xFF, out_sat=0.
//  6. Assert rst with 2 ops in flight -> next cycle out_valid=0, out_vec=0; no stale result later.

Source files
------------

// File: rtl/valu_addminmax_pipe.sv
// valu_addminmax_pipe: SIMD add/sub/min/max/compare unit, 3-stage valid/ready pipeline.
// Optional saturating ADD/SUB is compiled in when VALU_SAT_EN is defined.
module valu_addminmax_pipe #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SEW_WIDTH  = 2,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_vec0,
  input  logic [DATA_WIDTH-1:0] in_vec1,
  input  logic [SEW_WIDTH-1:0]  in_sew,
  input  logic [OP_WIDTH-1:0]   in_op,
  input  logic [1:0]            in_sat,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_vec,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_sat
);

  localparam int unsigned NMAX = DATA_WIDTH / 8;
  localparam logic [NMAX-1:0] ONE_N = NMAX'(1);

  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(4'h0);
  localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(4'h1);
  localparam logic [OP_WIDTH-1:0] OP_MINU = OP_WIDTH'(4'h2);
  localparam logic [OP_WIDTH-1:0] OP_MIN  = OP_WIDTH'(4'h3);
  localparam logic [OP_WIDTH-1:0] OP_MAXU = OP_WIDTH'(4'h4);
  localparam logic [OP_WIDTH-1:0] OP_MAX  = OP_WIDTH'(4'h5);
  localparam logic [OP_WIDTH-1:0] OP_SEQ  = OP_WIDTH'(4'h8);
  localparam logic [OP_WIDTH-1:0] OP_SNE  = OP_WIDTH'(4'h9);
  localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(4'hA);
  localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(4'hB);
  localparam logic [OP_WIDTH-1:0] OP_SLEU = OP_WIDTH'(4'hC);
  localparam logic [OP_WIDTH-1:0] OP_SLE  = OP_WIDTH'(4'hD);
  localparam logic [OP_WIDTH-1:0] OP_SGTU = OP_WIDTH'(4'hE);
  localparam logic [OP_WIDTH-1:0] OP_SGT  = OP_WIDTH'(4'hF);

  function automatic int unsigned elem_w(input logic [SEW_WIDTH-1:0] sew);
    return 32'd8 << sew;
  endfunction

  function automatic logic [63:0] elem(input logic [DATA_WIDTH-1:0] v, input int unsigned i,
                                       input int unsigned w, input logic [63:0] mask);
    return 64'(v >> (i * w)) & mask;
  endfunction

  // Stage registers
  logic                  s1_v_q, s2_v_q, out_valid_q;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q, s2_a_q, s2_b_q, s2_res_q, out_vec_q;
  logic [SEW_WIDTH-1:0]  s1_sew_q, s2_sew_q;
  logic [OP_WIDTH-1:0]   s1_op_q, s2_op_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q, out_addr_q;
  logic [NMAX-1:0]       s2_eq_q, s2_ltu_q, s2_lts_q;
  logic                  s2_sat_q, out_sat_q;
`ifdef VALU_SAT_EN
  logic [1:0]            s1_sat_q;
`else
  logic                  sat_unused;
  assign sat_unused = ^in_sat;
`endif

  // Stage handshake: a stage accepts when empty or when it drains this cycle
  logic s3_ready_c, s2_ready_c, s1_ready_c;
  assign s3_ready_c = !out_valid_q || out_ready;
  assign s2_ready_c = !s2_v_q || s3_ready_c;
  assign s1_ready_c = !s1_v_q || s2_ready_c;
  assign in_ready   = !rst && s1_ready_c;

  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign out_addr  = out_addr_q;
  assign out_sat   = out_sat_q;

  // S2 next-state: per-element add/sub (optionally clamped) plus compare flags
  logic [DATA_WIDTH-1:0] s2_res_d;
  logic [NMAX-1:0]       s2_eq_d, s2_ltu_d, s2_lts_d;
  logic                  s2_sat_d;
  int unsigned           w2, n2;
  logic [63:0]           mask2, sbit2, ea2, eb2, r2;
  logic                  is_arith2, is_sub2, ltu2, lts2, eq2;
`ifdef VALU_SAT_EN
  logic                  sa2, sb2, sr2, ovf_u2, ovf_s2;
`endif

  always_comb begin
    s2_res_d  = '0;
    s2_eq_d   = '0;
    s2_ltu_d  = '0;
    s2_lts_d  = '0;
    s2_sat_d  = 1'b0;
    w2        = elem_w(s1_sew_q);
    n2        = NMAX >> s1_sew_q;
    mask2     = (64'd1 << w2) - 64'd1;
    sbit2     = 64'd1 << (w2 - 32'd1);
    is_arith2 = (s1_op_q == OP_ADD) || (s1_op_q == OP_SUB);
    is_sub2   = (s1_op_q == OP_SUB);
    ea2 = '0; eb2 = '0; r2 = '0; ltu2 = 1'b0; lts2 = 1'b0; eq2 = 1'b0;
`ifdef VALU_SAT_EN
    sa2 = 1'b0; sb2 = 1'b0; sr2 = 1'b0; ovf_u2 = 1'b0; ovf_s2 = 1'b0;
`endif
    for (int unsigned i = 0; i < NMAX; i++) begin
      if (i < n2) begin
        ea2  = elem(s1_a_q, i, w2, mask2);
        eb2  = elem(s1_b_q, i, w2, mask2);
        r2   = (is_sub2 ? (ea2 - eb2) : (ea2 + eb2)) & mask2;
        ltu2 = ea2 < eb2;
        lts2 = (ea2 ^ sbit2) < (eb2 ^ sbit2);
        eq2  = ea2 == eb2;
`ifdef VALU_SAT_EN
        sa2    = |(ea2 & sbit2);
        sb2    = |(eb2 & sbit2);
        sr2    = |(r2 & sbit2);
        ovf_u2 = is_sub2 ? ltu2 : (r2 < ea2);
        ovf_s2 = (is_sub2 ? (sa2 != sb2) : (sa2 == sb2)) && (sr2 != sa2);
        if (is_arith2 && (s1_sat_q == 2'b10) && ovf_u2) begin
          r2       = is_sub2 ? 64'd0 : mask2;
          s2_sat_d = 1'b1;
        end else if (is_arith2 && (s1_sat_q == 2'b11) && ovf_s2) begin
          r2       = sa2 ? sbit2 : (mask2 >> 1);
          s2_sat_d = 1'b1;
        end
`endif
        s2_res_d = s2_res_d | (DATA_WIDTH'(r2) << (i * w2));
        s2_eq_d  = s2_eq_d  | (NMAX'(eq2)  << i);
        s2_ltu_d = s2_ltu_d | (NMAX'(ltu2) << i);
        s2_lts_d = s2_lts_d | (NMAX'(lts2) << i);
      end
    end
  end

  // S3 next-state: pick arithmetic result, min/max element, or packed compare mask
  logic [DATA_WIDTH-1:0] out_vec_d;
  logic                  out_sat_d;
  int unsigned           w3, n3;
  logic [63:0]           mask3, ea3, eb3, pick3;
  logic                  eqb3, ltub3, ltsb3, cbit3;

  always_comb begin
    out_vec_d = '0;
    out_sat_d = 1'b0;
    w3        = elem_w(s2_sew_q);
    n3        = NMAX >> s2_sew_q;
    mask3     = (64'd1 << w3) - 64'd1;
    ea3 = '0; eb3 = '0; pick3 = '0; eqb3 = 1'b0; ltub3 = 1'b0; ltsb3 = 1'b0; cbit3 = 1'b0;
    if ((s2_op_q == OP_ADD) || (s2_op_q == OP_SUB)) begin
      out_vec_d = s2_res_q;
      out_sat_d = s2_sat_q;
    end else begin
      for (int unsigned i = 0; i < NMAX; i++) begin
        if (i < n3) begin
          ea3   = elem(s2_a_q, i, w3, mask3);
          eb3   = elem(s2_b_q, i, w3, mask3);
          eqb3  = |((s2_eq_q  >> i) & ONE_N);
          ltub3 = |((s2_ltu_q >> i) & ONE_N);
          ltsb3 = |((s2_lts_q >> i) & ONE_N);
          pick3 = '0;
          cbit3 = 1'b0;
          case (s2_op_q)
            OP_MINU: pick3 = ltub3 ? ea3 : eb3;
            OP_MIN:  pick3 = ltsb3 ? ea3 : eb3;
            OP_MAXU: pick3 = ltub3 ? eb3 : ea3;
            OP_MAX:  pick3 = ltsb3 ? eb3 : ea3;
            OP_SEQ:  cbit3 = eqb3;
            OP_SNE:  cbit3 = !eqb3;
            OP_SLTU: cbit3 = ltub3;
            OP_SLT:  cbit3 = ltsb3;
            OP_SLEU: cbit3 = ltub3 || eqb3;
            OP_SLE:  cbit3 = ltsb3 || eqb3;
            OP_SGTU: cbit3 = !(ltub3 || eqb3);
            OP_SGT:  cbit3 = !(ltsb3 || eqb3);
            default: ;
          endcase
          out_vec_d = out_vec_d | (DATA_WIDTH'(pick3) << (i * w3)) | (DATA_WIDTH'(cbit3) << i);
        end
      end
    end
  end

  // S1: operand capture
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
    end else if (s1_ready_c) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_a_q    <= in_vec0;
        s1_b_q    <= in_vec1;
        s1_sew_q  <= in_sew;
        s1_op_q   <= in_op;
        s1_addr_q <= in_addr;
`ifdef VALU_SAT_EN
        s1_sat_q  <= in_sat;
`endif
      end
    end
  end

  // S2: arithmetic result and compare flags
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q <= 1'b0;
    end else if (s2_ready_c) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_a_q    <= s1_a_q;
        s2_b_q    <= s1_b_q;
        s2_res_q  <= s2_res_d;
        s2_eq_q   <= s2_eq_d;
        s2_ltu_q  <= s2_ltu_d;
        s2_lts_q  <= s2_lts_d;
        s2_sat_q  <= s2_sat_d;
        s2_sew_q  <= s1_sew_q;
        s2_op_q   <= s1_op_q;
        s2_addr_q <= s1_addr_q;
      end
    end
  end

  // S3: output register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_addr_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (s3_ready_c) begin
      out_valid_q <= s2_v_q;
      if (s2_v_q) begin
        out_vec_q  <= out_vec_d;
        out_addr_q <= s2_addr_q;
        out_sat_q  <= out_sat_d;
      end
    end
  end

endmodule

// File: tb/tb_valu_addminmax_pipe.sv
// Directed bench for valu_addminmax_pipe (64-bit datapath).
module tb_valu_addminmax_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [63:0] in_vec0, in_vec1, out_vec;
  logic [1:0]  in_sew, in_sat;
  logic [3:0]  in_op;
  logic [31:0] in_addr, out_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  valu_addminmax_pipe #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .SEW_WIDTH(2), .OP_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vec0(in_vec0), .in_vec1(in_vec1), .in_sew(in_sew), .in_op(in_op),
    .in_sat(in_sat), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_addr(out_addr), .out_sat(out_sat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated op through an empty pipe with out_ready high
  task automatic run_op(input string tag, input logic [1:0] sew, input logic [3:0] op,
                        input logic [1:0] sat, input logic [63:0] a, input logic [63:0] b,
                        input logic [31:0] addr, input logic [63:0] ev, input logic es);
    int lat;
    int wt;
    in_sew = sew; in_op = op; in_sat = sat; in_vec0 = a; in_vec1 = b; in_addr = addr;
    in_valid = 1'b1; out_ready = 1'b1;
    #2;
    wt = 0;
    while (!in_ready && wt < 10) begin tick(); #2; wt++; end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    #2;
    while (!out_valid && lat < 10) begin tick(); #2; lat++; end
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_vec"}, out_vec, ev);
    check({tag, "_sat"}, 64'(out_sat), 64'(es));
    check({tag, "_addr"}, 64'(out_addr), 64'(addr));
    tick();
  endtask

  initial begin
    int sent;
    int rcvd;
    int gaps;
    int vcnt;
    logic saw_full;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_vec0 = '0; in_vec1 = '0; in_sew = '0; in_op = '0; in_sat = '0; in_addr = '0;
    tick(); tick(); #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_vec", out_vec, 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    rst = 1'b0;
    tick();

    // Wrapping byte add and assorted element widths/opcodes
    run_op("add8_wrap", 2'd0, 4'h0, 2'b00, 64'h0000_0000_0000_FF01, 64'h0000_0000_0000_0101, 32'h11, 64'h0000_0000_0000_0002, 1'b0);
    run_op("slt32",  2'd2, 4'hB, 2'b00, 64'h0000_0005_FFFF_FFFF, 64'h0000_0005_0000_0000, 32'h12, 64'h1, 1'b0);
    run_op("maxu32", 2'd2, 4'h4, 2'b00, 64'h0000_0005_FFFF_FFFF, 64'h0000_0005_0000_0000, 32'h13, 64'h0000_0005_FFFF_FFFF, 1'b0);
    run_op("sltu32", 2'd2, 4'hA, 2'b00, 64'h0000_0005_FFFF_FFFF, 64'h0000_0005_0000_0000, 32'h14, 64'h0, 1'b0);
    run_op("sle32",  2'd2, 4'hD, 2'b00, 64'h0000_0005_FFFF_FFFF, 64'h0000_0005_0000_0000, 32'h15, 64'h3, 1'b0);
    run_op("seq32",  2'd2, 4'h8, 2'b00, 64'h0000_0005_FFFF_FFFF, 64'h0000_0005_0000_0000, 32'h16, 64'h2, 1'b0);
    run_op("minu32", 2'd2, 4'h2, 2'b00, 64'h0000_0005_FFFF_FFFF, 64'h0000_0005_0000_0000, 32'h17, 64'h0000_0005_0000_0000, 1'b0);
    run_op("min32",  2'd2, 4'h3, 2'b00, 64'h0000_0005_FFFF_FFFF, 64'h0000_0005_0000_0000, 32'h18, 64'h0000_0005_FFFF_FFFF, 1'b0);
    run_op("max32",  2'd2, 4'h5, 2'b00, 64'h0000_0005_FFFF_FFFF, 64'h0000_0005_0000_0000, 32'h19, 64'h0000_0005_0000_0000, 1'b0);
    run_op("sgt32",  2'd2, 4'hF, 2'b00, 64'h0000_0005_FFFF_FFFF, 64'h0000_0005_0000_0000, 32'h1A, 64'h0, 1'b0);
    run_op("sne32",  2'd2, 4'h9, 2'b00, 64'h0000_0005_FFFF_FFFF, 64'h0000_0005_0000_0000, 32'h1B, 64'h1, 1'b0);
    run_op("sgtu16", 2'd1, 4'hE, 2'b00, 64'h0001_0002_0003_0004, 64'h0002_0002_0002_0002, 32'h1C, 64'h3, 1'b0);
    run_op("sleu16", 2'd1, 4'hC, 2'b00, 64'h0001_0002_0003_0004, 64'h0002_0002_0002_0002, 32'h1D, 64'hC, 1'b0);
    run_op("sub64",  2'd3, 4'h1, 2'b00, 64'h0000_0001_0000_0000, 64'h1, 32'h1E, 64'h0000_0000_FFFF_FFFF, 1'b0);
    run_op("rsvd6",  2'd0, 4'h6, 2'b11, 64'h5, 64'h3, 32'h1F, 64'h0, 1'b0);
    run_op("sne8",   2'd0, 4'h9, 2'b00, 64'h0102_0304_0506_0708, 64'h0102_0304_0000_0000, 32'h20, 64'h0F, 1'b0);
    run_op("sub16_wrap", 2'd1, 4'h1, 2'b00, 64'h0, 64'h1, 32'h21, 64'h0000_0000_0000_FFFF, 1'b0);

    // Saturation modes (wrap when the feature is compiled out)
`ifdef VALU_SAT_EN
    run_op("sadd8",  2'd0, 4'h0, 2'b11, 64'h7F, 64'h01, 32'h30, 64'h7F, 1'b1);
    run_op("usub8",  2'd0, 4'h1, 2'b10, 64'h00, 64'h01, 32'h31, 64'h00, 1'b1);
    run_op("sadd16_neg", 2'd1, 4'h0, 2'b11, 64'h8000, 64'hFFFF, 32'h32, 64'h8000, 1'b1);
`else
    run_op("sadd8",  2'd0, 4'h0, 2'b11, 64'h7F, 64'h01, 32'h30, 64'h80, 1'b0);
    run_op("usub8",  2'd0, 4'h1, 2'b10, 64'h00, 64'h01, 32'h31, 64'hFF, 1'b0);
    run_op("sadd16_neg", 2'd1, 4'h0, 2'b11, 64'h8000, 64'hFFFF, 32'h32, 64'h7FFF, 1'b0);
`endif
    run_op("maxu8_satign", 2'd0, 4'h4, 2'b11, 64'h7F, 64'h01, 32'h33, 64'h7F, 1'b0);

    // Eight back-to-back ops with a five-cycle output stall
    sent = 0; rcvd = 0; gaps = 0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid  = (sent < 8);
      in_sew = 2'd3; in_op = 4'h0; in_sat = 2'b00;
      in_vec0 = 64'(sent); in_vec1 = 64'd100; in_addr = 32'h100 + 32'(sent);
      #2;
      if (!out_ready && !in_ready) saw_full = 1'b1;
      if (cyc > 8 && !out_valid) gaps++;
      if (out_valid && !out_ready) check("stall_hold_addr", 64'(out_addr), 64'(32'h100 + 32'(rcvd)));
      if (out_valid && out_ready) begin
        check("stream_addr", 64'(out_addr), 64'(32'h100 + 32'(rcvd)));
        check("stream_vec", out_vec, 64'(rcvd + 100));
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    check("stream_rcvd", 64'(rcvd), 64'd8);
    check("stream_full_backpressure", 64'(saw_full), 64'd1);
    check("stream_no_gaps", 64'(gaps), 64'd0);
    tick(); tick(); #2;
    check("stream_no_dup", 64'(out_valid), 64'd0);
    tick();

    // Single op stalled at the output; in_ready stays high until all stages fill
    out_ready = 1'b0;
    in_sew = 2'd3; in_op = 4'h0; in_sat = 2'b00;
    in_vec0 = 64'd1; in_vec1 = 64'd1; in_addr = 32'h200; in_valid = 1'b1;
    #2; check("fill_rdy0", 64'(in_ready), 64'd1);
    tick(); in_valid = 1'b0;
    #2; check("fill_rdy1", 64'(in_ready), 64'd1);
    tick();
    #2; check("fill_rdy2", 64'(in_ready), 64'd1);
    tick();
    #2; check("fill_x_held", 64'(out_valid), 64'd1);
    check("fill_rdy3", 64'(in_ready), 64'd1);
    in_vec0 = 64'd2; in_addr = 32'h201; in_valid = 1'b1;
    #1; tick();
    in_vec0 = 64'd3; in_addr = 32'h202;
    #2; check("fill_rdy4", 64'(in_ready), 64'd1);
    tick();
    in_vec0 = 64'd4; in_addr = 32'h203;
    #2; check("fill_full_rdy", 64'(in_ready), 64'd0);
    tick();
    #2; check("fill_full_rdy2", 64'(in_ready), 64'd0);
    check("fill_hold_addr", 64'(out_addr), 64'h200);
    check("fill_hold_vec", out_vec, 64'd2);
    in_valid = 1'b0; out_ready = 1'b1;
    #1; check("drain_x", 64'(out_addr), 64'h200);
    tick(); #2;
    check("drain_y", 64'(out_addr), 64'h201);
    check("drain_y_vec", out_vec, 64'd3);
    tick(); #2;
    check("drain_z", 64'(out_addr), 64'h202);
    check("drain_z_vec", out_vec, 64'd4);
    tick(); #2;
    check("drain_empty", 64'(out_valid), 64'd0);
    tick();

    // Reset with two ops in flight
    out_ready = 1'b1;
    in_vec0 = 64'd7; in_addr = 32'h300; in_valid = 1'b1;
    tick();
    in_vec0 = 64'd8; in_addr = 32'h301;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    #2; check("midrst_in_ready", 64'(in_ready), 64'd0);
    tick(); #2;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_vec", out_vec, 64'd0);
    check("midrst_out_addr", 64'(out_addr), 64'd0);
    rst = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick(); #2;
      if (out_valid) vcnt++;
    end
    check("midrst_no_stale", 64'(vcnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
